// File: rtl/cpu_lsu_pkg.sv
// cpu_lsu_pkg: shared encodings for the SELEN load/store unit.
//   - command encodings from the control decoder (LD_CMD, ST_CMD)
//   - access size encodings carried in sx_cntl[1:0] (FULL, HALF, BYTE, UPPER)
//   - sign control carried in sx_cntl[2] (SIGN, UNSIGN)
//   - FSM state type and a misalignment helper
package cpu_lsu_pkg;

  localparam logic [1:0] LD_CMD = 2'b11;
  localparam logic [1:0] ST_CMD = 2'b10;

  localparam logic SIGN   = 1'b1;
  localparam logic UNSIGN = 1'b0;

  typedef enum logic [1:0] {
    FULL  = 2'b00,
    HALF  = 2'b01,
    BYTE  = 2'b10,
    UPPER = 2'b11   // reserved encoding, rejected as an illegal size
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_RESP = 2'b10
  } state_e;

  // True when the low address bits do not match the natural alignment of the size.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
    logic mis;
    case (size)
      HALF:    mis = lo[0];
      FULL:    mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/cpu_lsu_align.sv
// cpu_lsu_align: combinational lane logic for the load/store unit.
//   Store side (st_*): byte enables and lane-replicated write data from the
//     access size and low address bits presented at accept time.
//   Load side (ld_*): selects the addressed byte/half of the read word and
//     sign- or zero-extends it to 32 bits using the latched access attributes.
// Misaligned low bits are truncated here: a half uses only lo[1], a word
// ignores lo entirely.
module cpu_lsu_align
  import cpu_lsu_pkg::*;
(
  input  size_e       st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  size_e       ld_size,
  input  logic        ld_sign,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store lane enables and data replication.
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = 32'h0000_0000;
    case (st_size)
      BYTE: begin
        st_be    = 4'b0001 << st_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      HALF: begin
        st_be    = st_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      FULL: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
      default: begin
        st_be    = 4'b0000;
        st_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Load lane selection and sign/zero extension.
  always_comb begin
    case (ld_lo)
      2'b00:   byte_s = ld_rdata[7:0];
      2'b01:   byte_s = ld_rdata[15:8];
      2'b10:   byte_s = ld_rdata[23:16];
      2'b11:   byte_s = ld_rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (ld_lo[1]) begin
      half_s = ld_rdata[31:16];
    end else begin
      half_s = ld_rdata[15:0];
    end
    case (ld_size)
      BYTE:    ld_data = {{24{ld_sign & byte_s[7]}}, byte_s};
      HALF:    ld_data = {{16{ld_sign & half_s[15]}}, half_s};
      FULL:    ld_data = ld_rdata;
      default: ld_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/cpu_lsu.sv
// cpu_lsu: load/store unit of the SELEN execute/memory stage.
//   Accepts a load (cmd 11) or store (cmd 10) from the stage, runs a single
//   req/ack transaction on the data-memory port and returns an extended load
//   result. Stalls upstream until the access completes.
// Ports:
//   clk, rst (async, active-high)
//   ex_valid, cmd[1:0], sx_cntl[2:0], addr[31:0], wdata[31:0]  - from EX
//   lsu_stall (comb), ld_valid, ld_data[31:0], lsu_err          - to pipeline
//   dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata           - to memory
//   dmem_ack, dmem_rdata                                        - from memory
// Parameter TMO_CYCLES (2..255): REQ cycles without ack before abort.
// Build option LSU_MISALIGN_TRAP_EN: when defined, misaligned half/word
// accesses raise lsu_err without a memory request; otherwise the low address
// bits are truncated and the access proceeds.
module cpu_lsu
  import cpu_lsu_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [1:0]  cmd,
  input  logic [2:0]  sx_cntl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        lsu_stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        lsu_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

  state_e      state_r, state_nxt_s;
  logic [7:0]  cnt_r;
  size_e       size_s, size_r;
  logic        sign_r;
  logic [1:0]  lo_r;
  logic        accept_s, bad_s, tmo_s, rd_done_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_rep_s, ld_ext_s;
  logic        ld_valid_r, lsu_err_r, dmem_we_r;
  logic [31:0] ld_data_r, dmem_addr_r, dmem_wdata_r;
  logic [3:0]  dmem_be_r;

  assign size_s    = size_e'(sx_cntl[1:0]);
  assign accept_s  = (state_r == S_IDLE) && ex_valid && ((cmd == LD_CMD) || (cmd == ST_CMD));
  assign tmo_s     = (cnt_r == TMO_LAST);
  assign rd_done_s = (state_r == S_REQ) && dmem_ack && !dmem_we_r;

`ifdef LSU_MISALIGN_TRAP_EN
  assign bad_s = (size_s == UPPER) || is_misaligned(size_s, addr[1:0]);
`else
  assign bad_s = (size_s == UPPER);
`endif

  cpu_lsu_align u_align (
    .st_size  (size_s),
    .st_lo    (addr[1:0]),
    .st_data  (wdata),
    .st_be    (be_s),
    .st_wdata (wdata_rep_s),
    .ld_size  (size_r),
    .ld_sign  (sign_r),
    .ld_lo    (lo_r),
    .ld_rdata (dmem_rdata),
    .ld_data  (ld_ext_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; bad accesses skip REQ and report from RESP.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = bad_s ? S_RESP : S_REQ;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (dmem_ack || tmo_s) begin
          state_nxt_s = S_RESP;
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_RESP:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM outputs: request follows the state register so reset drops it at once.
  always_comb begin
    dmem_req  = (state_r == S_REQ);
    lsu_stall = !rst && (accept_s || (state_r == S_REQ));
  end

  // Timeout counter: cleared on accept, counts unacknowledged REQ cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 8'd0;
    end else if (accept_s) begin
      cnt_r <= 8'd0;
    end else if ((state_r == S_REQ) && !dmem_ack && !tmo_s) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Access attribute latches, captured on accept and stable through REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_we_r    <= 1'b0;
      dmem_addr_r  <= 32'h0000_0000;
      dmem_be_r    <= 4'b0000;
      dmem_wdata_r <= 32'h0000_0000;
      sign_r       <= UNSIGN;
      size_r       <= FULL;
      lo_r         <= 2'b00;
    end else if (accept_s) begin
      dmem_we_r    <= (cmd == ST_CMD);
      dmem_addr_r  <= {addr[31:2], 2'b00};
      dmem_be_r    <= be_s;
      dmem_wdata_r <= wdata_rep_s;
      sign_r       <= sx_cntl[2];
      size_r       <= size_s;
      lo_r         <= addr[1:0];
    end else begin
      dmem_we_r    <= dmem_we_r;
      dmem_addr_r  <= dmem_addr_r;
      dmem_be_r    <= dmem_be_r;
      dmem_wdata_r <= dmem_wdata_r;
      sign_r       <= sign_r;
      size_r       <= size_r;
      lo_r         <= lo_r;
    end
  end

  // Completion outputs: pulses are set on entry to RESP, load data is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_valid_r <= 1'b0;
      lsu_err_r  <= 1'b0;
      ld_data_r  <= 32'h0000_0000;
    end else begin
      ld_valid_r <= rd_done_s;
      lsu_err_r  <= (accept_s && bad_s) || ((state_r == S_REQ) && !dmem_ack && tmo_s);
      if (rd_done_s) begin
        ld_data_r <= ld_ext_s;
      end else begin
        ld_data_r <= ld_data_r;
      end
    end
  end

  assign ld_valid   = ld_valid_r;
  assign lsu_err    = lsu_err_r;
  assign ld_data    = ld_data_r;
  assign dmem_we    = dmem_we_r;
  assign dmem_addr  = dmem_addr_r;
  assign dmem_be    = dmem_be_r;
  assign dmem_wdata = dmem_wdata_r;

endmodule

// File: tb/tb_cpu_lsu.sv
// tb_cpu_lsu: directed self-checking bench for cpu_lsu with TMO_CYCLES=4.
// Inputs are driven 2 time units after the rising edge and outputs are
// checked 1 unit later, well away from the next edge.
module tb_cpu_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [1:0]  cmd;
  logic [2:0]  sx_cntl;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        lsu_stall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        lsu_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_lsu #(.TMO_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .cmd        (cmd),
    .sx_cntl    (sx_cntl),
    .addr       (addr),
    .wdata      (wdata),
    .lsu_stall  (lsu_stall),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .lsu_err    (lsu_err),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [2:0] sx,
                       input logic [31:0] a, input logic [31:0] wd);
    ex_valid = v;
    cmd      = c;
    sx_cntl  = sx;
    addr     = a;
    wdata    = wd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b1, 2'b11, 3'b000, 32'h40, 32'h0);
    step();
    step();
    #1;
    n_tests++; if (lsu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b exp 0", lsu_stall); end
    n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", dmem_req); end
    n_tests++; if ({ld_valid, lsu_err, dmem_we} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b exp 000", {ld_valid, lsu_err, dmem_we}); end
    n_tests++; if (ld_data !== 32'h0) begin n_fail++; $display("FAIL rst_ld_data: got %h exp 0", ld_data); end
    n_tests++; if ({dmem_addr, dmem_be, dmem_wdata} !== 68'h0) begin n_fail++; $display("FAIL rst_dmem: got %h %b %h exp 0", dmem_addr, dmem_be, dmem_wdata); end
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    rst = 1'b0;
    step();
  endtask

  // LB signed, addr 0x103, zero-wait ack.
  task automatic test_lb_signed();
    drive(1'b1, 2'b11, 3'b110, 32'h103, 32'h0);
    #1;
    n_tests++; if (lsu_stall !== 1'b1) begin n_fail++; $display("FAIL lb_stall_n: got %b exp 1", lsu_stall); end
    step();
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_FFFF;
    #1;
    n_tests++; if ({dmem_req, dmem_we, lsu_stall} !== 3'b101) begin n_fail++; $display("FAIL lb_req: got %b exp 101", {dmem_req, dmem_we, lsu_stall}); end
    n_tests++; if (dmem_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b exp 1000", dmem_be); end
    n_tests++; if (dmem_addr !== 32'h100) begin n_fail++; $display("FAIL lb_addr: got %h exp 100", dmem_addr); end
    step();
    dmem_ack = 1'b0;
    #1;
    n_tests++; if ({ld_valid, lsu_err, lsu_stall, dmem_req} !== 4'b1000) begin n_fail++; $display("FAIL lb_done: got %b exp 1000", {ld_valid, lsu_err, lsu_stall, dmem_req}); end
    n_tests++; if (ld_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h exp ffffff80", ld_data); end
    step();
    #1;
    n_tests++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL lb_pulse: got %b exp 0", ld_valid); end
  endtask

  // LHU, addr 0x202, three wait cycles before ack.
  task automatic test_lhu_wait();
    int stalls = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) drive(1'b1, 2'b11, 3'b001, 32'h202, 32'h0);
      else        drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
      dmem_ack   = (i == 4);
      dmem_rdata = (i == 4) ? 32'hBEEF_1234 : 32'hDEAD_DEAD;
      #1;
      if (lsu_stall === 1'b1) stalls++;
      if (i == 2) begin
        n_tests++; if ({dmem_req, dmem_be} !== 5'b11100) begin n_fail++; $display("FAIL lhu_be: got %b exp 11100", {dmem_req, dmem_be}); end
      end
      if (i == 5) begin
        n_tests++; if (ld_valid !== 1'b1) begin n_fail++; $display("FAIL lhu_valid: got %b exp 1", ld_valid); end
        n_tests++; if (ld_data !== 32'h0000_BEEF) begin n_fail++; $display("FAIL lhu_data: got %h exp 0000beef", ld_data); end
      end
      step();
    end
    dmem_ack = 1'b0;
    n_tests++; if (stalls != 5) begin n_fail++; $display("FAIL lhu_stall_cycles: got %0d exp 5", stalls); end
  endtask

  // SH, addr 0x2: upper half lanes, replicated data, no load result.
  task automatic test_sh();
    drive(1'b1, 2'b10, 3'b001, 32'h2, 32'h0000_ABCD);
    step();
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
    #1;
    n_tests++; if ({dmem_req, dmem_we, dmem_be} !== 6'b111100) begin n_fail++; $display("FAIL sh_ctl: got %b exp 111100", {dmem_req, dmem_we, dmem_be}); end
    n_tests++; if (dmem_wdata !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_wdata: got %h exp abcdabcd", dmem_wdata); end
    n_tests++; if (dmem_addr !== 32'h0) begin n_fail++; $display("FAIL sh_addr: got %h exp 0", dmem_addr); end
    step();
    dmem_ack = 1'b0;
    #1;
    n_tests++; if ({ld_valid, lsu_err, lsu_stall} !== 3'b000) begin n_fail++; $display("FAIL sh_done: got %b exp 000", {ld_valid, lsu_err, lsu_stall}); end
    n_tests++; if (ld_data !== 32'h0000_BEEF) begin n_fail++; $display("FAIL sh_ld_hold: got %h exp 0000beef", ld_data); end
    step();
  endtask

  // LW with no ack: four REQ cycles, then an error pulse at N+5.
  task automatic test_timeout();
    int reqs = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) drive(1'b1, 2'b11, 3'b000, 32'h10, 32'h0);
      else        drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
      #1;
      if (dmem_req === 1'b1) reqs++;
      if (i == 5) begin
        n_tests++; if ({lsu_err, ld_valid, lsu_stall} !== 3'b100) begin n_fail++; $display("FAIL tmo_err: got %b exp 100", {lsu_err, ld_valid, lsu_stall}); end
      end
      if (i == 6) begin
        n_tests++; if ({lsu_err, dmem_req} !== 2'b00) begin n_fail++; $display("FAIL tmo_idle: got %b exp 00", {lsu_err, dmem_req}); end
      end
      step();
    end
    n_tests++; if (reqs != 4) begin n_fail++; $display("FAIL tmo_req_cycles: got %0d exp 4", reqs); end
  endtask

  // Illegal size goes straight to an error without a request.
  task automatic test_illegal_size();
    drive(1'b1, 2'b11, 3'b011, 32'h30, 32'h0);
    #1;
    n_tests++; if (lsu_stall !== 1'b1) begin n_fail++; $display("FAIL ill_stall: got %b exp 1", lsu_stall); end
    step();
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    #1;
    n_tests++; if ({lsu_err, dmem_req, ld_valid, lsu_stall} !== 4'b1000) begin n_fail++; $display("FAIL ill_err: got %b exp 1000", {lsu_err, dmem_req, ld_valid, lsu_stall}); end
    step();
  endtask

  // LW at 0x6: trap or truncation depending on the build option.
  task automatic test_misalign();
    drive(1'b1, 2'b11, 3'b000, 32'h6, 32'h0);
    step();
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    #1;
    n_tests++; if ({lsu_err, dmem_req, ld_valid} !== 3'b100) begin n_fail++; $display("FAIL mis_trap: got %b exp 100", {lsu_err, dmem_req, ld_valid}); end
    step();
`else
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    #1;
    n_tests++; if ({dmem_req, dmem_be} !== 5'b11111) begin n_fail++; $display("FAIL mis_req: got %b exp 11111", {dmem_req, dmem_be}); end
    n_tests++; if (dmem_addr !== 32'h4) begin n_fail++; $display("FAIL mis_addr: got %h exp 4", dmem_addr); end
    step();
    dmem_ack = 1'b0;
    #1;
    n_tests++; if ({ld_valid, lsu_err} !== 2'b10 || ld_data !== 32'h1234_5678) begin n_fail++; $display("FAIL mis_data: got %b %h exp 10 12345678", {ld_valid, lsu_err}, ld_data); end
    step();
`endif
  endtask

  // LBU then SB: instruction held during RESP is not re-accepted; next accept at N+3.
  task automatic test_back_to_back();
    drive(1'b1, 2'b11, 3'b010, 32'h101, 32'h0);
    step();
    dmem_ack = 1'b1; dmem_rdata = 32'h0000_A500;
    #1;
    n_tests++; if ({dmem_req, dmem_be} !== 5'b10010) begin n_fail++; $display("FAIL b2b_lbu_be: got %b exp 10010", {dmem_req, dmem_be}); end
    step();
    dmem_ack = 1'b0;
    #1;
    n_tests++; if ({ld_valid, lsu_stall} !== 2'b10 || ld_data !== 32'h0000_00A5) begin n_fail++; $display("FAIL b2b_lbu_data: got %b %h exp 10 000000a5", {ld_valid, lsu_stall}, ld_data); end
    step();
    drive(1'b1, 2'b10, 3'b010, 32'h3, 32'h0000_0012);
    #1;
    n_tests++; if ({lsu_stall, dmem_req} !== 2'b10) begin n_fail++; $display("FAIL b2b_accept: got %b exp 10", {lsu_stall, dmem_req}); end
    step();
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    dmem_ack = 1'b1;
    #1;
    n_tests++; if ({dmem_req, dmem_we, dmem_be} !== 6'b111000 || dmem_wdata !== 32'h1212_1212) begin n_fail++; $display("FAIL b2b_sb: got %b %h exp 111000 12121212", {dmem_req, dmem_we, dmem_be}, dmem_wdata); end
    step();
    dmem_ack = 1'b0;
    #1;
    n_tests++; if (ld_valid !== 1'b0 || ld_data !== 32'h0000_00A5) begin n_fail++; $display("FAIL b2b_sb_done: got %b %h exp 0 000000a5", ld_valid, ld_data); end
    step();
  endtask

  // Reset during REQ drops the request at once; late ack is ignored.
  task automatic test_reset_mid_access();
    drive(1'b1, 2'b11, 3'b000, 32'h20, 32'h0);
    step();
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    #1;
    n_tests++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req: got %b exp 1", dmem_req); end
    rst = 1'b1;
    #1;
    n_tests++; if ({dmem_req, lsu_stall} !== 2'b00) begin n_fail++; $display("FAIL rmid_drop: got %b exp 00", {dmem_req, lsu_stall}); end
    step();
    rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    step();
    dmem_ack = 1'b0;
    #1;
    n_tests++; if ({ld_valid, lsu_err, dmem_req, lsu_stall} !== 4'b0000 || ld_data !== 32'h0) begin n_fail++; $display("FAIL rmid_ignore: got %b %h exp 0000 0", {ld_valid, lsu_err, dmem_req, lsu_stall}, ld_data); end
    step();
    drive(1'b1, 2'b11, 3'b000, 32'h24, 32'h0);
    step();
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    #1;
    n_tests++; if (dmem_addr !== 32'h24) begin n_fail++; $display("FAIL rmid_lw_addr: got %h exp 24", dmem_addr); end
    step();
    dmem_ack = 1'b0;
    #1;
    n_tests++; if (ld_valid !== 1'b1 || ld_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rmid_lw_data: got %b %h exp 1 cafef00d", ld_valid, ld_data); end
    step();
  endtask

  initial begin
    test_reset();
    test_lb_signed();
    test_lhu_wait();
    test_sh();
    test_timeout();
    test_illegal_size();
    test_misalign();
    test_back_to_back();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
